uart_cmd_parser: RTL
====================

# uart_cmd_parser

Device-side receiver for the host matrix-command protocol. It sits between the board UART's one-cycle `rx_done`/`rx_data` byte stream and the matrix buffers in `fumpy_top`. It decodes the opcode byte and the four dimension bytes, validates them, and optionally returns an ACK byte. It then reassembles the big-endian FP32 operand stream into 32-bit words, tagged by matrix and element index.

## Interface
- `OP_MATMUL`, default 8'h03: opcode accepted for matrix multiply; any other opcode is rejected.
- `MAX_DIM`, default 16: maximum legal value of each dimension byte.
- `ACK_EN`, default 1: when 1, the block sends `ACK_BYTE` after a valid header and before any operand data.
- `ACK_BYTE`, default 8'hA5: value of the ACK byte.
- `TIMEOUT`, default 1_000_000: maximum number of `clk` cycles allowed between consecutive received bytes once a packet has started.
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `rx_done`, input, 1: one-cycle strobe marking that `rx_data` is valid.
- `rx_data`, input, 8: received byte.
- `tx_done`, input, 1: pulse from the UART transmitter when a byte has finished sending.
- `tx_send`, output, 1: one-cycle request to the UART transmitter to send `tx_byte`.
- `tx_byte`, output, 8: byte to transmit.
- `a_height`, `a_width`, `h_height`, `h_width`, output, 8 each: latched dimensions.
- `hdr_valid`, output, 1: one-cycle pulse when a header has been accepted.
- `fp_data`, output, 32: assembled operand word.
- `fp_valid`, output, 1: one-cycle pulse; `fp_data`, `fp_mat` and `fp_idx` are valid in the same cycle.
- `fp_mat`, output, 1: matrix tag; 0 = A, 1 = H.
- `fp_idx`, output, 16: row-major element index within the current matrix, starting at 0.
- `pkt_done`, output, 1: one-cycle pulse after the last H word.
- `err`, output, 1: one-cycle pulse on any rejection or timeout.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- **States:** IDLE, HDR, ACK, LOAD_A, LOAD_H.
- **IDLE**
  - On `rx_done` with `rx_data == OP_MATMUL`: go to HDR and clear the header byte counter.
  - On `rx_done` with any other opcode: pulse `err` and stay in IDLE.
- **HDR**
  - Capture four bytes, in order, into `a_height`, `a_width`, `h_height`, `h_width`.
  - After the fourth byte, validate the header:
    - every dimension is non-zero and ≤ `MAX_DIM`;
    - `a_width == h_height`.
  - On failure: pulse `err` and return to IDLE.
  - On success: pulse `hdr_valid` and load the element target `a_height*a_width` (16-bit product).
  - Next state is ACK when `ACK_EN=1`, otherwise LOAD_A.
- **ACK**
  - Assert `tx_send` for exactly one cycle with `tx_byte = ACK_BYTE`.
  - Wait for `tx_done`, then go to LOAD_A.
  - `rx_done` strobes that arrive while in ACK are accepted and assembled; they are not lost.
- **LOAD_A / LOAD_H**
  - A 2-bit byte counter shifts bytes MSB-first: `word = {word[23:0], rx_data}`.
  - On the 4th byte, pulse `fp_valid` and then increment `fp_idx`.
  - When `fp_idx` reaches target−1 in LOAD_A: go to LOAD_H, reset `fp_idx` to 0, and set target = `h_height*h_width`.
  - When `fp_idx` reaches target−1 in LOAD_H: pulse `pkt_done` and return to IDLE.
- **Timeout**
  - A gap counter clears on every `rx_done` and counts in all states except IDLE and ACK.
  - When the counter reaches `TIMEOUT`, pulse `err`, discard the partial word, and go to IDLE.
- **Reset** (`rst` asserted, including mid-packet): state returns to IDLE, and all counters, the word register and the dimension registers are cleared. The next byte after reset is treated as an opcode.

## Timing
- **Reset values:** all outputs are 0. This includes `tx_byte` = 8'h00, all dimension registers = 0, `fp_data` = 0, and `busy` = 0.
- All outputs are registered.
- `hdr_valid`/`err` assert in the cycle after the `rx_done` of the 4th dimension byte.
- `fp_valid` asserts in the cycle after the `rx_done` of each word's 4th byte.
- `pkt_done` asserts in the same cycle as the final `fp_valid`.
- `tx_send` asserts in the cycle after `hdr_valid`.
- Back-to-back `rx_done` on consecutive cycles must be handled at full rate with no byte dropped.
- `busy` rises in the cycle after the opcode `rx_done` and falls in the same cycle as `pkt_done` or `err`.
- `rx_done` arriving in the same cycle as a timeout: the timeout wins and the byte is dropped.

## Test plan
- **Full packet:** send 8'h03, dims 4,4,4,4 → `hdr_valid`, then ACK byte 8'hA5 sent. Then send A = 1.0…16.0 and H = 1.0…16.0 (e.g. 1.0 = bytes 3F 80 00 00) → 32 `fp_valid` pulses.
  - A words carry `fp_mat=0`, `fp_idx` 0..15; `fp_data` for index 3 is 32'h40800000.
  - H words carry `fp_mat=1`.
  - `pkt_done` coincides with the H index-15 pulse.
- **Bad opcode:** send 8'h7E → `err` pulse, state stays IDLE. A following valid packet is parsed correctly.
- **Dimension mismatch:** send dims 2,3,4,2 → `err`, no `tx_send`, back to IDLE.
- **Out-of-range dimension:** send dims 0,4,4,4, then 17,4,4,4 → `err` each time.
- **Timeout:** with `TIMEOUT=100`, stop sending after 2 bytes of the first A word → `err` at gap cycle 100, `busy`=0, and no `fp_valid`.
- **Reset mid-packet:** assert `rst` after 5 A words → all outputs return to 0. A fresh 2x2·2x2 packet then yields 4+4 words with `fp_idx` starting at 0.

Source files
------------

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_cmd_parser                                                  |
// | Purpose : Decodes the matrix-command header, returns an ACK and assembles  |
// |           the big-endian FP32 operand stream into tagged 32-bit words.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_cmd_parser #(
    parameter logic [7:0] OP_MATMUL = 8'h03,
    parameter int         MAX_DIM   = 16,
    parameter bit         ACK_EN    = 1'b1,
    parameter logic [7:0] ACK_BYTE  = 8'hA5,
    parameter int         TIMEOUT   = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic        tx_done,
    output logic        tx_send,
    output logic [7:0]  tx_byte,
    output logic [7:0]  a_height,
    output logic [7:0]  a_width,
    output logic [7:0]  h_height,
    output logic [7:0]  h_width,
    output logic        hdr_valid,
    output logic [31:0] fp_data,
    output logic        fp_valid,
    output logic        fp_mat,
    output logic [15:0] fp_idx,
    output logic        pkt_done,
    output logic        err,
    output logic        busy
);
    localparam int         c_GAP_W  = $clog2(TIMEOUT + 1);
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_HDR    = 3'd1;
    localparam logic [2:0] c_ACK    = 3'd2;
    localparam logic [2:0] c_LOAD_A = 3'd3;
    localparam logic [2:0] c_LOAD_H = 3'd4;

    logic [2:0]         r_state, w_next;
    logic [1:0]         r_hdr_cnt, r_byte_cnt;
    logic [23:0]        r_word;
    logic [15:0]        r_idx, r_target;
    logic [c_GAP_W-1:0] r_gap;
    logic               r_ack_sent;

    logic w_timeout, w_rx, w_loading, w_word_done, w_last, w_hdr_last, w_hdr_ok;
    logic w_opcode_ok, w_err, w_hdr_valid, w_tx_send;

    function automatic logic dim_ok(input logic [7:0] d);
        return (d != 8'd0) && (int'(d) <= MAX_DIM);
    endfunction

    // A byte landing on the timeout cycle is dropped: the timeout wins.
    assign w_timeout   = (r_state == c_HDR || r_state == c_LOAD_A || r_state == c_LOAD_H)
                         && (r_gap == c_GAP_W'(TIMEOUT));
    assign w_rx        = rx_done && !w_timeout;
    assign w_opcode_ok = (r_state == c_IDLE) && rx_done && (rx_data == OP_MATMUL);
    assign w_loading   = (r_state == c_ACK) || (r_state == c_LOAD_A) || (r_state == c_LOAD_H);
    assign w_word_done = w_loading && w_rx && (r_byte_cnt == 2'd3);
    assign w_last      = w_word_done && (r_idx == r_target - 16'd1);
    assign w_hdr_last  = (r_state == c_HDR) && w_rx && (r_hdr_cnt == 2'd3);
    assign w_hdr_ok    = dim_ok(a_height) && dim_ok(a_width) && dim_ok(h_height)
                         && dim_ok(rx_data) && (a_width == h_height);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (w_opcode_ok) w_next = c_HDR;
            c_HDR: begin
                if (w_timeout)       w_next = c_IDLE;
                else if (w_hdr_last) w_next = !w_hdr_ok ? c_IDLE : (ACK_EN ? c_ACK : c_LOAD_A);
            end
            // Operand bytes may already stream in while the ACK is in flight.
            c_ACK: begin
                if (w_last)                       w_next = c_LOAD_H;
                else if (tx_done && r_ack_sent)   w_next = c_LOAD_A;
            end
            c_LOAD_A: begin
                if (w_timeout)   w_next = c_IDLE;
                else if (w_last) w_next = c_LOAD_H;
            end
            c_LOAD_H: begin
                if (w_timeout || w_last) w_next = c_IDLE;
            end
            default:  w_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_err       = ((r_state == c_IDLE) && rx_done && (rx_data != OP_MATMUL))
                      || w_timeout || (w_hdr_last && !w_hdr_ok);
        w_hdr_valid = w_hdr_last && w_hdr_ok;
        w_tx_send   = (r_state == c_ACK) && !r_ack_sent;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            hdr_valid <= 1'b0;
            tx_send   <= 1'b0;
            tx_byte   <= 8'h00;
            fp_valid  <= 1'b0;
            fp_data   <= 32'h0;
            fp_mat    <= 1'b0;
            fp_idx    <= 16'h0;
            pkt_done  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            err       <= w_err;
            hdr_valid <= w_hdr_valid;
            tx_send   <= w_tx_send;
            fp_valid  <= w_word_done;
            pkt_done  <= w_last && (r_state == c_LOAD_H);
            busy      <= (w_next != c_IDLE);
            if (w_tx_send) tx_byte <= ACK_BYTE;
            if (w_word_done) begin
                fp_data <= {r_word, rx_data};
                fp_mat  <= (r_state == c_LOAD_H);
                fp_idx  <= r_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr_cnt  <= 2'd0;
            r_byte_cnt <= 2'd0;
            r_word     <= 24'h0;
            r_idx      <= 16'h0;
            r_target   <= 16'h0;
            r_gap      <= '0;
            r_ack_sent <= 1'b0;
            a_height   <= 8'h0;
            a_width    <= 8'h0;
            h_height   <= 8'h0;
            h_width    <= 8'h0;
        end else begin
            if (w_timeout || rx_done || r_state == c_IDLE || r_state == c_ACK)
                r_gap <= '0;
            else
                r_gap <= r_gap + c_GAP_W'(1);

            if (w_tx_send)        r_ack_sent <= 1'b1;
            else if (w_hdr_valid) r_ack_sent <= 1'b0;

            if (w_opcode_ok) begin
                r_hdr_cnt <= 2'd0;
            end else if ((r_state == c_HDR) && w_rx) begin
                r_hdr_cnt <= r_hdr_cnt + 2'd1;
                case (r_hdr_cnt)
                    2'd0:    a_height <= rx_data;
                    2'd1:    a_width  <= rx_data;
                    2'd2:    h_height <= rx_data;
                    default: h_width  <= rx_data;
                endcase
            end

            if (w_hdr_valid) begin
                r_target <= 16'(a_height) * 16'(a_width);
                r_idx    <= 16'h0;
            end else if (w_word_done) begin
                if (w_last) begin
                    r_idx    <= 16'h0;
                    r_target <= 16'(h_height) * 16'(h_width);
                end else begin
                    r_idx    <= r_idx + 16'd1;
                end
            end

            // Any return to IDLE discards a partially assembled word.
            if (w_next == c_IDLE || w_hdr_valid) begin
                r_byte_cnt <= 2'd0;
                r_word     <= 24'h0;
            end else if (w_loading && w_rx) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_word     <= {r_word[15:0], rx_data};
            end
        end
    end
endmodule
`default_nettype wire
